metro_access_ctrl: RTL and testbench

Parametrised successor to the single-digit metro turnstile FSM. Accepts a multi-digit access code one digit per `validate_code` strobe and compares it against a parameter secret. On a match it opens the access door for a bounded time, with an early close when a passenger passes. Repeated failures lock the gate for a fixed time. It sits between the keypad/reader front end and the door actuator driver; `state_out` feeds the station status panel.

---
 rtl/metro_access_pkg.sv | 20 ++
 rtl/metro_access_ctrl_if.sv | 25 ++
 rtl/metro_access_ctrl_cycle_timer.sv | 28 ++
 rtl/metro_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_metro_access_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/metro_access_pkg.sv
// Shared types and helpers for the metro access controller: state encoding
// and the sizing function for the shared timer.
package metro_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_OPEN    = 2'b10,
    ST_LOCKED  = 2'b11
  } state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/metro_access_ctrl_if.sv
// Keypad/door/status bundle between the front end, the controller and the panel.
interface metro_access_ctrl_if #(
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

  logic              validate_code;
  logic [CODE_W-1:0] access_code;
  logic              pass_through;
  logic              open_access_door;
  logic              locked;
  logic [1:0]        state_out;
  logic [FAIL_W-1:0] fail_count;

  modport master (
    output validate_code, access_code, pass_through,
    input  open_access_door, locked, state_out, fail_count
  );

  modport slave (
    input  validate_code, access_code, pass_through,
    output open_access_door, locked, state_out, fail_count
  );
endinterface

// File: rtl/metro_access_ctrl_cycle_timer.sv
// Loadable down-counter shared by the entry timeout, door hold and lockout.
module cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (en && (count_q != '0))
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/metro_access_ctrl.sv
// Multi-digit access-code gate controller: digit collection, door hold with
// early close on passage, and lockout after repeated wrong codes.
module metro_access_ctrl #(
  parameter int unsigned                     CODE_W         = 4,
  parameter int unsigned                     CODE_LEN       = 4,
  parameter logic [CODE_LEN*CODE_W-1:0]      SECRET         = 16'h9135,
  parameter int unsigned                     MAX_FAILS      = 3,
  parameter int unsigned                     OPEN_CYCLES    = 8,
  parameter int unsigned                     LOCKOUT_CYCLES = 16,
  parameter int unsigned                     ENTRY_TIMEOUT  = 10
) (
  input logic                clk,
  input logic                rst,
  metro_access_ctrl_if.slave bus
);
  import metro_access_pkg::*;

  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam int unsigned IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned TW = $clog2(max3(OPEN_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT) + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            mismatch_q, mismatch_d;
  logic [FW-1:0]   fail_q, fail_d, fail_inc;
  logic [IW-1:0]   cur_idx;
  logic [CODE_W-1:0] exp_digit;
  logic            digit_bad, mismatch_next, eval_code, door_raw;
  logic            t_load, t_en, t_zero;
  logic [TW-1:0]   t_val;

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  // In IDLE the incoming digit is always digit 0, whatever idx holds.
  assign cur_idx = (state_q == ST_IDLE) ? '0 : idx_q;

  always_comb begin
    exp_digit = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++)
      if (cur_idx == IW'(i))
        exp_digit = SECRET[(CODE_LEN-1-i)*CODE_W +: CODE_W];
  end

  assign digit_bad     = (bus.access_code != exp_digit);
  assign mismatch_next = ((state_q == ST_COLLECT) ? mismatch_q : 1'b0) | digit_bad;
  assign fail_inc      = fail_q + FW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    t_load     = 1'b0;
    t_val      = '0;
    t_en       = 1'b0;
    door_raw   = 1'b0;
    eval_code  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.validate_code) begin
          mismatch_d = digit_bad;
          if (CODE_LEN == 1) begin
            eval_code = 1'b1;
          end else begin
            state_d = ST_COLLECT;
            idx_d   = IW'(1);
            t_load  = 1'b1;
            t_val   = TW'(ENTRY_TIMEOUT - 1);
          end
        end
      end
      ST_COLLECT: begin
        // A strobe takes priority over an expiring entry timer.
        if (bus.validate_code) begin
          mismatch_d = mismatch_next;
          if (idx_q == LAST_IDX) begin
            eval_code = 1'b1;
          end else begin
            idx_d  = idx_q + IW'(1);
            t_load = 1'b1;
            t_val  = TW'(ENTRY_TIMEOUT - 1);
          end
        end else if (t_zero) begin
          state_d    = ST_IDLE;
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else begin
          t_en = 1'b1;
        end
      end
      ST_OPEN: begin
        door_raw = 1'b1;
        if (t_zero || bus.pass_through) state_d = ST_IDLE;
        else                            t_en    = 1'b1;
      end
      ST_LOCKED: begin
        if (t_zero) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end else begin
          t_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (eval_code) begin
      idx_d      = '0;
      mismatch_d = 1'b0;
      if (!mismatch_next) begin
        door_raw = 1'b1;
        state_d  = ST_OPEN;
        fail_d   = '0;
        t_load   = 1'b1;
        t_val    = TW'(OPEN_CYCLES - 1);
      end else begin
        fail_d = fail_inc;
        if (fail_inc == FW'(MAX_FAILS)) begin
          state_d = ST_LOCKED;
          t_load  = 1'b1;
          t_val   = TW'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
    end
  end

  assign bus.open_access_door = door_raw & ~rst;
  assign bus.locked           = (state_q == ST_LOCKED);
  assign bus.state_out        = state_q;
  assign bus.fail_count       = fail_q;
endmodule

// File: tb/tb_metro_access_ctrl.sv
// Directed bench for metro_access_ctrl: default 4-digit instance plus a
// single-digit instance, checked per cycle through an expectation queue.
module tb_metro_access_ctrl;
  typedef struct packed {
    logic       door;
    logic       lk;
    logic [1:0] st;
    logic [1:0] fc;
  } obs_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  int   total = 0;
  int   bad   = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  metro_access_ctrl_if #(.CODE_W(4), .MAX_FAILS(3)) bus  ();
  metro_access_ctrl_if #(.CODE_W(4), .MAX_FAILS(3)) bus2 ();

  metro_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  metro_access_ctrl #(
    .CODE_LEN (1),
    .SECRET   (4'h9)
  ) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  task automatic compare(input string tag, input obs_t got);
    obs_t want;
    want = sb.pop_front();
    total++;
    assert (got.door === want.door) else begin
      bad++;
      $error("FAIL %s door got=%0b exp=%0b", tag, got.door, want.door);
    end
    total++;
    assert (got.lk === want.lk) else begin
      bad++;
      $error("FAIL %s locked got=%0b exp=%0b", tag, got.lk, want.lk);
    end
    total++;
    assert (got.st === want.st) else begin
      bad++;
      $error("FAIL %s state got=%0b exp=%0b", tag, got.st, want.st);
    end
    total++;
    assert (got.fc === want.fc) else begin
      bad++;
      $error("FAIL %s fail_count got=%0d exp=%0d", tag, got.fc, want.fc);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, queue the expected
  // outputs for that cycle, compare on the falling edge.
  task automatic cyc(input string tag, input bit sel, input logic v,
                     input logic [3:0] d, input logic p, input logic r,
                     input logic e_door, input logic e_lk,
                     input logic [1:0] e_st, input logic [1:0] e_fc);
    obs_t got;
    @(posedge clk);
    #1;
    if (!sel) begin
      bus.validate_code = v;
      bus.access_code   = d;
      bus.pass_through  = p;
      rst               = r;
    end else begin
      bus2.validate_code = v;
      bus2.access_code   = d;
      bus2.pass_through  = p;
      rst2               = r;
    end
    sb.push_back(obs_t'{e_door, e_lk, e_st, e_fc});
    @(negedge clk);
    if (!sel) got = {bus.open_access_door, bus.locked, bus.state_out, bus.fail_count};
    else      got = {bus2.open_access_door, bus2.locked, bus2.state_out, bus2.fail_count};
    compare(tag, got);
  endtask

  task automatic idle(input string tag, input int unsigned n, input logic e_door,
                      input logic e_lk, input logic [1:0] e_st, input logic [1:0] e_fc);
    for (int unsigned k = 0; k < n; k++)
      cyc(tag, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, e_door, e_lk, e_st, e_fc);
  endtask

  task automatic digit(input string tag, input logic [3:0] d, input logic e_door,
                       input logic [1:0] e_st, input logic [1:0] e_fc);
    cyc(tag, 1'b0, 1'b1, d, 1'b0, 1'b0, e_door, 1'b0, e_st, e_fc);
  endtask

  initial begin
    bus.validate_code  = 1'b0;
    bus.access_code    = 4'h0;
    bus.pass_through   = 1'b0;
    bus2.validate_code = 1'b0;
    bus2.access_code   = 4'h0;
    bus2.pass_through  = 1'b0;

    cyc("reset", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);
    cyc("reset", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0);

    // correct code, full hold, strobe ignored while open
    digit("a_d0", 4'h9, 1'b0, 2'b00, 2'd0);
    digit("a_d1", 4'h1, 1'b0, 2'b01, 2'd0);
    digit("a_d2", 4'h3, 1'b0, 2'b01, 2'd0);
    digit("a_d3", 4'h5, 1'b1, 2'b01, 2'd0);
    digit("a_ign", 4'h9, 1'b1, 2'b10, 2'd0);
    idle("a_open", 7, 1'b1, 1'b0, 2'b10, 2'd0);
    idle("a_close", 1, 1'b0, 1'b0, 2'b00, 2'd0);

    // early close on the second open cycle; pass_through ignored in IDLE
    digit("b_d0", 4'h9, 1'b0, 2'b00, 2'd0);
    digit("b_d1", 4'h1, 1'b0, 2'b01, 2'd0);
    digit("b_d2", 4'h3, 1'b0, 2'b01, 2'd0);
    digit("b_d3", 4'h5, 1'b1, 2'b01, 2'd0);
    cyc("b_open1", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'd0);
    cyc("b_pass", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'd0);
    cyc("b_closed", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
    idle("b_idle", 1, 1'b0, 1'b0, 2'b00, 2'd0);

    // three wrong codes back to back -> lockout
    for (int unsigned e = 0; e < 3; e++) begin
      digit("c_d0", 4'h9, 1'b0, 2'b00, 2'(e));
      digit("c_d1", 4'h1, 1'b0, 2'b01, 2'(e));
      digit("c_d2", 4'h3, 1'b0, 2'b01, 2'(e));
      digit("c_d3", 4'h4, 1'b0, 2'b01, 2'(e));
    end
    cyc("c_lk9", 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'd3);
    cyc("c_lk1", 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'd3);
    cyc("c_lk3", 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'd3);
    cyc("c_lk5", 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'd3);
    idle("c_locked", 12, 1'b0, 1'b1, 2'b11, 2'd3);
    idle("c_unlock", 1, 1'b0, 1'b0, 2'b00, 2'd0);

    // wrong code, abandoned entry keeps the count, right code clears it
    digit("d_w0", 4'h9, 1'b0, 2'b00, 2'd0);
    digit("d_w1", 4'h1, 1'b0, 2'b01, 2'd0);
    digit("d_w2", 4'h3, 1'b0, 2'b01, 2'd0);
    digit("d_w3", 4'h4, 1'b0, 2'b01, 2'd0);
    digit("d_p0", 4'h9, 1'b0, 2'b00, 2'd1);
    digit("d_p1", 4'h1, 1'b0, 2'b01, 2'd1);
    idle("d_wait", 10, 1'b0, 1'b0, 2'b01, 2'd1);
    idle("d_timeout", 1, 1'b0, 1'b0, 2'b00, 2'd1);
    digit("e_d0", 4'h9, 1'b0, 2'b00, 2'd1);
    digit("e_d1", 4'h1, 1'b0, 2'b01, 2'd1);
    digit("e_d2", 4'h3, 1'b0, 2'b01, 2'd1);
    digit("e_d3", 4'h5, 1'b1, 2'b01, 2'd1);
    idle("e_open", 8, 1'b1, 1'b0, 2'b10, 2'd0);
    idle("e_close", 1, 1'b0, 1'b0, 2'b00, 2'd0);

    // reset in the third open cycle forces the door low at once
    digit("f_d0", 4'h9, 1'b0, 2'b00, 2'd0);
    digit("f_d1", 4'h1, 1'b0, 2'b01, 2'd0);
    digit("f_d2", 4'h3, 1'b0, 2'b01, 2'd0);
    digit("f_d3", 4'h5, 1'b1, 2'b01, 2'd0);
    idle("f_open", 2, 1'b1, 1'b0, 2'b10, 2'd0);
    cyc("f_rst", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'd0);
    cyc("f_after", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);

    // reset mid-entry clears a nonzero fail count
    digit("g_w0", 4'h9, 1'b0, 2'b00, 2'd0);
    digit("g_w1", 4'h1, 1'b0, 2'b01, 2'd0);
    digit("g_w2", 4'h3, 1'b0, 2'b01, 2'd0);
    digit("g_w3", 4'h4, 1'b0, 2'b01, 2'd0);
    digit("g_d0", 4'h9, 1'b0, 2'b00, 2'd1);
    cyc("g_rst", 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'd1);
    cyc("g_after", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);

    // strobe arriving on the cycle the entry timer hits zero is consumed
    digit("h_d0", 4'h9, 1'b0, 2'b00, 2'd0);
    digit("h_d1", 4'h1, 1'b0, 2'b01, 2'd0);
    idle("h_wait", 9, 1'b0, 1'b0, 2'b01, 2'd0);
    digit("h_d2", 4'h3, 1'b0, 2'b01, 2'd0);
    digit("h_d3", 4'h5, 1'b1, 2'b01, 2'd0);
    idle("h_open", 8, 1'b1, 1'b0, 2'b10, 2'd0);
    idle("h_close", 1, 1'b0, 1'b0, 2'b00, 2'd0);

    // single-digit instance, secret 9
    cyc("s_rel", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
    cyc("s_0a", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
    cyc("s_0b", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd1);
    cyc("s_9", 1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd2);
    cyc("s_open", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
